// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the four-phase main sequencer.
// The state enum is encoded one-hot so the register value equals the phase output.
package main_fsm_pkg;

  localparam logic [3:0] Y_S0 = 4'b0001;
  localparam logic [3:0] Y_S1 = 4'b0010;
  localparam logic [3:0] Y_S2 = 4'b0100;
  localparam logic [3:0] Y_S3 = 4'b1000;

  typedef enum logic [3:0] {
    S0 = Y_S0,
    S1 = Y_S1,
    S2 = Y_S2,
    S3 = Y_S3
  } state_t;

  // Any non-one-hot register value decodes as phase S0.
  function automatic logic [3:0] state_to_y(state_t s);
    logic [3:0] v;
    case (s)
      S0:      v = Y_S0;
      S1:      v = Y_S1;
      S2:      v = Y_S2;
      S3:      v = Y_S3;
      default: v = Y_S0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Four-state Moore sequencer S0->S1->S2->S3->S0; each forward step gated by its own input.
// Output y is the registered one-hot phase; illegal register values recover to S0 in one cycle.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  output logic [3:0] y
);

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0:      w_next_state = i0 ? S1 : S0;
      S1:      w_next_state = i1 ? S2 : S1;
      S2:      w_next_state = i2 ? S3 : S2;
      S3:      w_next_state = S0;
      default: w_next_state = S0;
    endcase
  end

  assign y = state_to_y(r_state);

  a_y_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot(y));
  a_s3_wraps: assert property (@(posedge clock) disable iff (!reset)
                               (r_state == S3) |=> (r_state == S0));

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed plan steps followed by randomized stimulus
// checked against a phase-counter reference model.
module tb_main_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       i0    = 1'b0;
  logic       i1    = 1'b0;
  logic       i2    = 1'b0;
  logic [3:0] y;

  int vectors     = 0;
  int miscompares = 0;
  int phase       = 0;  // reference model: current phase index 0..3

  always #5 clock = ~clock;

  main_fsm dut (
    .clock (clock),
    .reset (reset),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .y     (y)
  );

  function automatic logic [3:0] model_y();
    logic [3:0] one;
    one = 4'b0001;
    return one << phase;
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    vectors++;
    assert (y === exp)
    else begin
      miscompares++;
      $error("FAIL %s: y=%b expected %b", tag, y, exp);
    end
  endtask

  // Apply inputs, take one rising edge, advance the model, then settle for sampling.
  task automatic step(input logic r, input logic a, input logic b, input logic c);
    logic [2:0] adv;
    reset = r;
    i0    = a;
    i1    = b;
    i2    = c;
    adv   = {c, b, a};
    @(posedge clock);
    if (!r)              phase = 0;
    else if (phase == 3) phase = 0;
    else if (adv[phase]) phase = phase + 1;
    #1;
  endtask

  task automatic dstep(input string tag, input logic r, input logic a, input logic b,
                       input logic c, input logic [3:0] exp);
    step(r, a, b, c);
    check(tag, exp);
  endtask

  initial begin
    logic [3:0] free_run [10];
    free_run = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    // Reset held with arbitrary inputs.
    for (int k = 0; k < 3; k++) begin
      dstep("reset_hold", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'b0001);
    end

    // Free run with all advance conditions high.
    for (int k = 0; k < 10; k++) begin
      dstep("free_run", 1'b1, 1'b1, 1'b1, 1'b1, free_run[k]);
    end

    // Stall in S1.
    dstep("stall_rst", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001);
    dstep("stall_to_s1", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      dstep("stall_hold", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010);
    end
    dstep("stall_release", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);

    // Unconditional wrap from S3.
    dstep("wrap_to_s3", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
    dstep("wrap_to_s0", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    dstep("wrap_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);

    // Inputs of other states are ignored in S0.
    dstep("isolate_s0", 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);
    dstep("isolate_s0", 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);

    // Reset mid-sequence from S2.
    dstep("mid_to_s1", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010);
    dstep("mid_to_s2", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
    dstep("mid_reset", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001);
    dstep("mid_release", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010);

    // Randomized run with between-edge glitches on the inputs.
    for (int k = 0; k < 400; k++) begin
      logic r;
      r  = ($urandom_range(0, 15) != 0);
      i0 = 1'($urandom);
      i1 = 1'($urandom);
      i2 = 1'($urandom);
      #2;
      step(r, 1'($urandom), 1'($urandom), 1'($urandom));
      check("random", model_y());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
